// File: rtl/fp_mult_pkg.sv
// Shared bit-index constants for the multiplier result stage.
// Status indices address the multiplier status byte; sticky indices address the exception flags.
package fp_mult_pkg;
  localparam int ST_ZERO = 0;
  localparam int ST_INF  = 1;
  localparam int ST_NV   = 2;
  localparam int ST_TINY = 3;
  localparam int ST_HUGE = 4;
  localparam int ST_NX   = 5;

  localparam int SK_NV = 0;
  localparam int SK_OF = 1;
  localparam int SK_UF = 2;
  localparam int SK_NX = 3;
endpackage

// File: rtl/fp_skid_buf.sv
// Generic 2-entry valid/ready register: main drives the outputs, skid catches the word
// accepted in the cycle main stalls. in_ready is a flop that is low exactly while skid is full.
module fp_skid_buf #(
  parameter int W = 40
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  logic         in_fire;
  logic         out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // Main/skid occupancy and data movement; main is always full while skid is full.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      in_ready   <= 1'b1;
    end else if (skid_valid) begin
      if (out_fire) begin
        out_data   <= skid_data;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end
    end else if (in_fire) begin
      if (!out_valid || out_fire) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        skid_valid <= 1'b1;
        skid_data  <= in_data;
        in_ready   <= 1'b0;
      end
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fp_mult_result_stage.sv
// Registered handshake stage after the FP multiplier: flush-to-zero at acceptance,
// sticky IEEE exception flags with a maskable interrupt, and a saturating result counter.
module fp_mult_result_stage
  import fp_mult_pkg::*;
#(
  parameter int sig_width = 23,
  parameter int exp_width = 8,
  parameter int CNT_W     = 16,
  localparam int isize    = sig_width + exp_width + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [isize-1:0] in_z,
  input  logic [7:0]       in_status,
  input  logic             ftz_en,
  input  logic             flag_clr,
  input  logic [3:0]       flag_mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [isize-1:0] out_z,
  output logic [7:0]       out_status,
  output logic [3:0]       sticky,
  output logic             exc_irq,
  output logic [CNT_W-1:0] res_cnt
);
  logic [isize-1:0] adj_z;
  logic [7:0]       adj_status;
  logic [3:0]       event_flags;
  logic             accept;

  assign accept = in_valid && in_ready;

  // Flush-to-zero keeps the sign; an invalid result is never flushed.
  always_comb begin
    adj_z      = in_z;
    adj_status = in_status;
    if (ftz_en && in_status[ST_TINY] && !in_status[ST_NV]) begin
      adj_z               = {in_z[isize-1], {(isize-1){1'b0}}};
      adj_status[ST_ZERO] = 1'b1;
      adj_status[ST_NX]   = 1'b1;
    end else begin
      adj_z      = in_z;
      adj_status = in_status;
    end
    event_flags        = 4'b0000;
    event_flags[SK_NV] = adj_status[ST_NV];
    event_flags[SK_OF] = adj_status[ST_HUGE];
    event_flags[SK_UF] = adj_status[ST_TINY] && adj_status[ST_NX];
    event_flags[SK_NX] = adj_status[ST_NX];
  end

  fp_skid_buf #(.W(isize + 8)) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   ({adj_z, adj_status}),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  ({out_z, out_status})
  );

  // Sticky flags (a same-cycle event survives the clear), interrupt level and result count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sticky  <= 4'b0000;
      exc_irq <= 1'b0;
      res_cnt <= '0;
    end else begin
      sticky  <= (flag_clr ? 4'b0000 : sticky) | (accept ? event_flags : 4'b0000);
      exc_irq <= |(sticky & flag_mask);
      if (accept && (res_cnt != {CNT_W{1'b1}})) begin
        res_cnt <= res_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
endmodule

// File: tb/tb_fp_mult_result_stage.sv
// Directed bench for fp_mult_result_stage; a second instance with a 4-bit counter
// exercises counter saturation on the same stimulus.
module tb_fp_mult_result_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_z;
  logic [7:0]  in_status;
  logic        ftz_en;
  logic        flag_clr;
  logic [3:0]  flag_mask;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_z;
  logic [7:0]  out_status;
  logic [3:0]  sticky;
  logic        exc_irq;
  logic [15:0] res_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_z4;
  logic [7:0]  out_status4;
  logic [3:0]  sticky4;
  logic        exc_irq4;
  logic [3:0]  res_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_mult_result_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_z(in_z), .in_status(in_status), .ftz_en(ftz_en), .flag_clr(flag_clr),
    .flag_mask(flag_mask), .out_valid(out_valid), .out_ready(out_ready),
    .out_z(out_z), .out_status(out_status), .sticky(sticky), .exc_irq(exc_irq),
    .res_cnt(res_cnt)
  );

  fp_mult_result_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_z(in_z), .in_status(in_status), .ftz_en(ftz_en), .flag_clr(flag_clr),
    .flag_mask(flag_mask), .out_valid(out_valid4), .out_ready(out_ready),
    .out_z(out_z4), .out_status(out_status4), .sticky(sticky4), .exc_irq(exc_irq4),
    .res_cnt(res_cnt4)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_z = 32'h0; in_status = 8'h00;
    ftz_en = 1'b0; flag_clr = 1'b0; flag_mask = 4'b0000; out_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_z", out_z, 32'h0);
    check("rst_sticky", sticky, 4'b0000);
    check("rst_irq", exc_irq, 1'b0);
    check("rst_cnt", res_cnt, 16'd0);
    rst_n = 1'b1;
    tick();

    // Pass-through
    in_valid = 1'b1; in_z = 32'h3FC00000; in_status = 8'h00;
    tick();
    in_valid = 1'b0;
    check("pt_valid", out_valid, 1'b1);
    check("pt_z", out_z, 32'h3FC00000);
    check("pt_status", out_status, 8'h00);
    check("pt_sticky", sticky, 4'b0000);
    check("pt_cnt", res_cnt, 16'd1);
    tick();
    check("pt_drain", out_valid, 1'b0);

    // Flush-to-zero on and off
    ftz_en = 1'b1; in_valid = 1'b1; in_z = 32'h80400000; in_status = 8'h28;
    tick();
    in_valid = 1'b0;
    check("ftz_z", out_z, 32'h80000000);
    check("ftz_status", out_status, 8'h29);
    check("ftz_sticky", sticky, 4'b1100);
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0;
    check("clr_sticky", sticky, 4'b0000);
    ftz_en = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("noftz_z", out_z, 32'h80400000);
    check("noftz_status", out_status, 8'h28);
    check("noftz_sticky", sticky, 4'b1100);
    check("noftz_cnt", res_cnt, 16'd3);

    // Clear colliding with a new NV+OF event
    flag_clr = 1'b1;
    tick();
    flag_clr = 1'b0; in_valid = 1'b1; in_z = 32'h3F800000; in_status = 8'h20;
    tick();
    check("nx_sticky", sticky, 4'b1000);
    flag_mask = 4'b0001; flag_clr = 1'b1; in_status = 8'h14;
    tick();
    flag_clr = 1'b0; in_valid = 1'b0;
    check("coll_sticky", sticky, 4'b0011);
    check("coll_irq_lag", exc_irq, 1'b0);
    tick();
    check("coll_irq", exc_irq, 1'b1);
    flag_mask = 4'b0100;
    tick();
    check("mask_irq", exc_irq, 1'b0);
    check("coll_cnt", res_cnt, 16'd5);

    // Backpressure: A to main, B to skid, C held upstream
    out_ready = 1'b0; in_status = 8'h00;
    in_valid = 1'b1; in_z = 32'hAAAA0001;
    check("bp_rdyA", in_ready, 1'b1);
    tick();
    in_z = 32'hBBBB0002;
    check("bp_rdyB", in_ready, 1'b1);
    tick();
    in_z = 32'hCCCC0003;
    check("bp_rdy_full", in_ready, 1'b0);
    tick();
    check("bp_hold_rdy", in_ready, 1'b0);
    check("bp_hold_valid", out_valid, 1'b1);
    check("bp_hold_z", out_z, 32'hAAAA0001);
    out_ready = 1'b1;
    tick();
    check("bp_outB", out_z, 32'hBBBB0002);
    check("bp_rdy_back", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    check("bp_outC", out_z, 32'hCCCC0003);
    check("bp_validC", out_valid, 1'b1);
    tick();
    check("bp_empty", out_valid, 1'b0);
    check("bp_cnt", res_cnt, 16'd8);

    // Reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; in_z = 32'hDDDD0004;
    tick();
    in_z = 32'hEEEE0005;
    tick();
    in_valid = 1'b0;
    check("mid_full", in_ready, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_valid", out_valid, 1'b0);
    check("mid_rdy", in_ready, 1'b1);
    check("mid_sticky", sticky, 4'b0000);
    check("mid_cnt", res_cnt, 16'd0);
    out_ready = 1'b1;
    tick();
    check("mid_noreplay1", out_valid, 1'b0);
    tick();
    check("mid_noreplay2", out_valid, 1'b0);

    // Counter saturation on the 4-bit instance
    in_valid = 1'b1; in_z = 32'h40000000; in_status = 8'h00;
    for (int i = 0; i < 20; i++) tick();
    in_valid = 1'b0;
    check("sat_cnt4", res_cnt4, 4'd15);
    check("sat_cnt16", res_cnt, 16'd20);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("sat_hold4", res_cnt4, 4'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fp_mult_result_stage.md
Name: fp_mult_result_stage

Overview:
Registered output stage placed directly downstream of the combinational floating-point multiplier. It consumes the product `z` and the 8-bit `status` vector, and adds a valid/ready handshake through a 2-entry skid buffer. It optionally flushes tiny results to zero, accumulates IEEE sticky exception flags, raises a maskable interrupt, and counts accepted results. This provides the pipeline boundary the multiplier lacks.

Parameters:
- sig_width, 23, fraction width of `z`.
- exp_width, 8, biased exponent width of `z`.
- isize, sig_width+exp_width+1, word width (derived; not overridden).
- CNT_W, 16, width of the saturating result counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  product and status valid from the multiplier.
- in_ready  out  1  stage can accept a product this cycle.
- in_z  in  isize  product word from the multiplier.
- in_status  in  8  multiplier status flags:
  - [0] zero, [1] infinity, [2] invalid, [3] tiny, [4] huge, [5] inexact.
  - [7:6] ignored.
- ftz_en  in  1  flush-to-zero enable, sampled on input acceptance.
- flag_clr  in  1  single-cycle pulse that clears all sticky flags.
- flag_mask  in  4  interrupt enable per sticky flag.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accepts the output word.
- out_z  out  isize  registered, possibly flushed, product.
- out_status  out  8  registered, possibly adjusted, status.
- sticky  out  4  sticky flags {NX, UF, OF, NV} = bits [3:0].
- exc_irq  out  1  level interrupt, equal to |(sticky & flag_mask), registered.
- res_cnt  out  CNT_W  count of accepted results, saturating.

Behaviour:
- Reset values: all outputs 0 except in_ready=1. Both buffer entries empty. A reset in mid-transfer discards buffered data with no output pulse.
- Handshakes:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - out_z and out_status are held stable while out_valid && !out_ready.
- Latency: 1 cycle from input acceptance to out_valid when the main register is empty or draining.
- Buffer: main register drives the outputs; skid register holds one extra entry.
  - in_ready is registered: it goes to 0 the cycle after the skid register fills.
  - in_ready returns to 1 the cycle after the skid entry moves to main.
  - An input is accepted in the cycle in_ready drops. If main is stalled, that input lands in skid.
  - Order is strictly preserved. No bubble under continuous valid/ready.
- FTZ, applied at acceptance: if ftz_en && in_status[3] && !in_status[2]:
  - z becomes {sign, all-zero}.
  - status[0] and status[5] are set.
  - All other status bits pass through unchanged.
- Sticky flag events, computed from the adjusted status at input acceptance:
  - NV = bit2.
  - OF = bit4.
  - UF = bit3 && bit5.
  - NX = bit5.
- Sticky update: sticky <= (flag_clr ? 0 : sticky) | event. A new event in the same cycle as flag_clr remains set.
- exc_irq updates one cycle after sticky, and also when flag_mask changes.
- res_cnt increments on each input acceptance, saturates at 2^CNT_W-1, and is not cleared by flag_clr.

Decomposition:
- Package fp_mult_pkg holds:
  - Status bit index constants: ST_ZERO=0, ST_INF=1, ST_NV=2, ST_TINY=3, ST_HUGE=4, ST_NX=5.
  - Sticky index constants: SK_NV=0, SK_OF=1, SK_UF=2, SK_NX=3.
- One natural sub-module: fp_skid_buf, a generic 2-entry valid/ready register of width isize+8. Flag, FTZ and counter logic stay in the top level.

Test Plan:
- Pass-through: in_z=32'h3FC00000, status 8'h00, out_ready=1. Required: out_z=32'h3FC00000 and out_status=8'h00 one cycle later; sticky=0; res_cnt=1.
- FTZ: in_z=32'h80400000, status 8'h28, ftz_en=1. Required: out_z=32'h80000000, out_status=8'h29, sticky=4'b1100. With ftz_en=0 the word passes unchanged and sticky is still 4'b1100.
- Backpressure: hold out_ready=0 and issue 3 back-to-back inputs A, B, C. Required:
  - in_ready falls after B is stored in skid; C is held upstream.
  - After out_ready=1, the outputs are A, B, C in consecutive cycles.
  - No drop and no duplicate.
- Clear collision: sticky=4'b1000, then flag_clr pulse in the same cycle as an accepted status 8'h14 (NV+OF). Required: sticky=4'b0011. With flag_mask=4'b0001, exc_irq=1 one cycle later.
- Saturation with CNT_W=4: accept 20 results. Required: res_cnt=15 and it stays 15.
- Reset mid-operation: both entries full, drive rst_n=0 for 1 cycle. Required: out_valid=0, in_ready=1, sticky=0, res_cnt=0 on the next cycle, and the old data never reappears.
